// File: rtl/snn_pkg.sv
// Shared constants and state encoding for the SNN image loader and the core's pixel counter.
package snn_pkg;

    localparam int NUM_PIX   = 784;
    localparam int NUM_BYTES = 98;
    localparam int ADDR_W    = 10;
    localparam int BCNT_W    = 7;

    typedef enum logic [1:0] {
        LOAD,
        KICK,
        BUSY
    } loader_state_t;

endpackage

// File: rtl/snn_img_buf.sv
// 98x8 image buffer: synchronous byte write, registered single-pixel read (LSB-first unpacking).
module snn_img_buf
    import snn_pkg::*;
#(
    parameter int DEPTH = NUM_BYTES,
    parameter int PIX   = NUM_PIX
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [BCNT_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic              q
);

    localparam logic [ADDR_W-1:0] PIX_LIM = ADDR_W'(PIX);

    logic [7:0] mem [DEPTH];
    logic       q_p1;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read stage: one-cycle latency to line up with the hidden-weight ROM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_p1 <= 1'b0;
        end else if (raddr < PIX_LIM) begin
            q_p1 <= mem[raddr[ADDR_W-1:3]][raddr[2:0]];
        end else begin
            q_p1 <= 1'b0;
        end
    end

    assign q = q_p1;

endmodule

// File: rtl/snn_image_loader.sv
// Loads a 98-byte binary image from the UART, kicks the SNN core and serves pixels to it.
// Optional idle-gap frame abort enabled by defining SNN_LOADER_TIMEOUT_EN.
module snn_image_loader
    import snn_pkg::*;
#(
    parameter int NUM_BYTES   = snn_pkg::NUM_BYTES,
    parameter int NUM_PIX     = snn_pkg::NUM_PIX,
    parameter int TIMEOUT_CYC = 2500000
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_rdy,
    output logic              clr_rx_rdy,
    input  logic [ADDR_W-1:0] addr_input_unit,
    output logic              q_input,
    output logic              start,
    input  logic              done,
    output logic              busy,
    output logic              frame_abort
);

    loader_state_t     state, state_nxt;
    logic [BCNT_W-1:0] byte_cnt;
    logic              guard;
    logic              accept;
    logic              last_byte;
    logic              timeout_hit;

    // guard masks the stale rx_rdy seen while the UART processes our clear
    assign accept    = (state == LOAD) && rx_rdy && !guard;
    assign last_byte = (byte_cnt == BCNT_W'(NUM_BYTES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (accept && last_byte) state_nxt = KICK;
            KICK:    state_nxt = BUSY;
            BUSY:    if (done) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    always_comb begin
        clr_rx_rdy = 1'b0;
        start      = 1'b0;
        busy       = 1'b0;
        case (state)
            LOAD: clr_rx_rdy = accept;
            KICK: begin
                start = 1'b1;
                busy  = 1'b1;
            end
            BUSY:    busy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            guard    <= 1'b0;
        end else begin
            guard <= accept;
            if (accept) begin
                byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
            end else if (timeout_hit) begin
                byte_cnt <= '0;
            end
        end
    end

`ifdef SNN_LOADER_TIMEOUT_EN
    localparam int IDLE_W = 22;

    logic [IDLE_W-1:0] idle_cnt;
    logic              idle_run;

    // Only a partially received frame can time out
    assign idle_run    = (state == LOAD) && (byte_cnt != '0);
    assign timeout_hit = idle_run && !accept && (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (!idle_run || accept || timeout_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign frame_abort = timeout_hit;
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign frame_abort    = 1'b0;
    assign unused_timeout = (TIMEOUT_CYC == 0);
`endif

    snn_img_buf #(
        .DEPTH (NUM_BYTES),
        .PIX   (NUM_PIX)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (accept),
        .waddr (byte_cnt),
        .wdata (rx_data),
        .raddr (addr_input_unit),
        .q     (q_input)
    );

endmodule

// File: tb/tb_snn_image_loader.sv
// Scoreboard bench for snn_image_loader: stimulus queues expected events, a negedge monitor checks them.
module tb_snn_image_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_rdy = 1'b0;
    logic       clr_rx_rdy;
    logic [9:0] addr_input_unit = 10'd0;
    logic       q_input;
    logic       start;
    logic       done = 1'b0;
    logic       busy;
    logic       frame_abort;

    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   clr_cnt = 0;
    int   last_clr = 0;
    int   last_acc = 0;
    bit   have_clr = 1'b0;
    bit   rd_issue = 1'b0;
    bit   rd_stage = 1'b0;
    int   start_q[$];
    int   abort_q[$];
    bit   rd_q[$];
    logic [7:0] exp_mem [98];

    snn_image_loader #(
        .NUM_BYTES   (98),
        .NUM_PIX     (784),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rx_data         (rx_data),
        .rx_rdy          (rx_rdy),
        .clr_rx_rdy      (clr_rx_rdy),
        .addr_input_unit (addr_input_unit),
        .q_input         (q_input),
        .start           (start),
        .done            (done),
        .busy            (busy),
        .frame_abort     (frame_abort)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rd_stage <= rd_issue;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Monitor: pops expectations whenever the DUT presents an output event
    always @(negedge clk) begin
        if (rd_stage) begin
            chk("rd_pending", int'(rd_q.size() > 0), 1);
            if (rd_q.size() > 0) chk("q_input", int'(q_input), int'(rd_q.pop_front()));
        end
        if (clr_rx_rdy) begin
            clr_cnt++;
            if (have_clr) chk("clr_spacing", int'((cyc - last_clr) >= 2), 1);
            last_clr = cyc;
            have_clr = 1'b1;
        end
        if (start) begin
            chk("start_pending", int'(start_q.size() > 0), 1);
            if (start_q.size() > 0) chk("start_cycle", cyc, start_q.pop_front());
        end
        if (frame_abort) begin
            chk("abort_pending", int'(abort_q.size() > 0), 1);
            if (abort_q.size() > 0) chk("abort_cycle", cyc, abort_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // UART model: present a byte, wait for clr_rx_rdy; hold keeps rdy high across the clear
    task automatic send_byte(input logic [7:0] b, input bit hold);
        int n;
        bit got;
        n   = 0;
        got = 1'b0;
        if (!hold) tick();
        rx_data = b;
        rx_rdy  = 1'b1;
        while (!got && n < 50) begin
            @(negedge clk);
            got = clr_rx_rdy;
            if (got) last_acc = cyc;
            tick();
            n++;
        end
        chk("accept_seen", int'(got), 1);
        if (!hold) rx_rdy = 1'b0;
    endtask

    task automatic send_bytes(input int lo, input int hi, input bit hold);
        for (int k = lo; k <= hi; k++) send_byte(exp_mem[k], hold);
    endtask

    task automatic sweep(input int lo, input int hi);
        for (int a = lo; a <= hi; a++) begin
            addr_input_unit = 10'(a);
            rd_issue        = 1'b1;
            rd_q.push_back(a < 784 ? exp_mem[a / 8][a % 8] : 1'b0);
            tick();
        end
        rd_issue = 1'b0;
        tick();
        tick();
    endtask

    task automatic pulse_done();
        chk("busy_before_done", int'(busy), 1);
        done = 1'b1;
        tick();
        done = 1'b0;
        @(negedge clk);
        chk("busy_after_done", int'(busy), 0);
        tick();
    endtask

    initial begin
        int c0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_clr", int'(clr_rx_rdy), 0);
        chk("rst_start", int'(start), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_q", int'(q_input), 0);
        chk("rst_abort", int'(frame_abort), 0);
        rst_n = 1'b1;
        tick();

        // Frame 1: bytes 0x01..0x62
        for (int k = 0; k < 98; k++) exp_mem[k] = 8'(k + 1);
        c0 = clr_cnt;
        send_bytes(0, 97, 1'b0);
        start_q.push_back(last_acc + 1);
        tick();
        chk("clr_count_frame1", clr_cnt - c0, 98);
        chk("busy_after_start", int'(busy), 1);
        pulse_done();

        // Frame 2: all 0xA5, full pixel sweep plus out-of-range addresses
        for (int k = 0; k < 98; k++) exp_mem[k] = 8'hA5;
        send_bytes(0, 97, 1'b0);
        start_q.push_back(last_acc + 1);
        tick();
        sweep(0, 783);
        sweep(784, 784);
        sweep(1023, 1023);

        // Back-pressure while busy: a pending 0xFF must not be consumed
        rx_data = 8'hFF;
        rx_rdy  = 1'b1;
        c0 = clr_cnt;
        repeat (1000) tick();
        chk("clr_count_busy", clr_cnt - c0, 0);
        sweep(0, 15);
        sweep(768, 783);
        done = 1'b1;
        @(negedge clk);
        chk("clr_on_done", int'(clr_rx_rdy), 0);
        chk("busy_on_done", int'(busy), 1);
        tick();
        done = 1'b0;
        @(negedge clk);
        chk("busy_after_done2", int'(busy), 0);
        chk("pending_accept", int'(clr_rx_rdy), 1);
        tick();

        // Frame 3: byte 0 is the pending 0xFF, rest sent with rdy held high
        exp_mem[0] = 8'hFF;
        for (int k = 1; k < 98; k++) exp_mem[k] = 8'((k * 37) & 8'hFF);
        send_bytes(1, 97, 1'b1);
        start_q.push_back(last_acc + 1);
        rx_rdy = 1'b0;
        tick();
        sweep(0, 783);
        pulse_done();

        // Reset mid-frame after 50 bytes
        for (int k = 0; k < 98; k++) exp_mem[k] = 8'(k ^ 8'h3C);
        send_bytes(0, 49, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_clr", int'(clr_rx_rdy), 0);
        chk("midrst_start", int'(start), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_q", int'(q_input), 0);
        chk("midrst_abort", int'(frame_abort), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        send_bytes(0, 47, 1'b0);
        repeat (5) tick();
        chk("no_start_48", int'(busy), 0);
        send_bytes(48, 97, 1'b0);
        start_q.push_back(last_acc + 1);
        tick();
        pulse_done();

        // Idle gap after a 10-byte partial frame
        send_bytes(0, 9, 1'b0);
`ifdef SNN_LOADER_TIMEOUT_EN
        abort_q.push_back(last_acc + 100);
        repeat (150) tick();
        send_bytes(0, 97, 1'b0);
`else
        repeat (150) tick();
        send_bytes(10, 97, 1'b0);
`endif
        start_q.push_back(last_acc + 1);
        tick();
        pulse_done();

        repeat (5) tick();
        chk("start_q_drained", start_q.size(), 0);
        chk("abort_q_drained", abort_q.size(), 0);
        chk("rd_q_drained", rd_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation stalled at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
